// File: rtl/adder_test_pkg.sv
// Shared types and widths for the adder datapath test sequencer.
package adder_test_pkg;

   localparam int VEC_W  = 9;    // {a, b, Cin} vector index
   localparam int SUM_W  = 5;    // one adder result: 4-bit sum plus carry
   localparam int Q_W    = 10;   // {CLA half, RCA half} from the datapath
   localparam int OP_W   = 4;    // operand width
   localparam int CNT_W  = 10;   // error counter, holds 0..512
   localparam int DLY_W  = 4;    // hold counter, PIPE_DLY up to 15
   localparam int HALVES = 2;    // RCA half at index 0, CLA half at index 1

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      LOAD,
      CHK_RCA,
      CHK_CLA,
      NEXT,
      DONE
   } state_t;

   // Reference sum a + b + cin, zero-extended to one adder result width
   function automatic logic [SUM_W-1:0] ref_sum(input logic [OP_W-1:0] a,
                                                input logic [OP_W-1:0] b,
                                                input logic            cin);
      return SUM_W'(a) + SUM_W'(b) + SUM_W'(cin);
   endfunction

endpackage

// File: rtl/adder_ref_model.sv
// Combinational checker: expected sum and half-select match for one vector.
module adder_ref_model
   import adder_test_pkg::*;
(
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   input  logic             Cin,
   input  logic [Q_W-1:0]   Q,
   input  logic             select,
   output logic [SUM_W-1:0] exp,
   output logic             match
);

   logic [HALVES-1:0] half_ok;

   assign exp = ref_sum(a, b, Cin);

   // The selected half must carry the sum; the other half must read as zero
   for (genvar gi = 0; gi < HALVES; gi++) begin : g_half
      assign half_ok[gi] = (Q[gi*SUM_W +: SUM_W] == ((select == 1'(gi)) ? exp : '0));
   end

   assign match = &half_ok;

endmodule

// File: rtl/adder_test_sequencer.sv
// Sweeps all {a,b,Cin} vectors through the adder datapath and checks both halves.
module adder_test_sequencer
   import adder_test_pkg::*;
#(
   parameter int unsigned PIPE_DLY     = 1,
   parameter bit          STOP_ON_FAIL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [OP_W-1:0]  a,
   output logic [OP_W-1:0]  b,
   output logic             Cin,
   output logic             load,
   output logic             select,
   input  logic [Q_W-1:0]   Q,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [VEC_W-1:0] fail_vec
);

   localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(PIPE_DLY - 1);
   localparam logic [VEC_W-1:0] VEC_LAST = '1;

   state_t             state_reg, state_next;
   logic [VEC_W-1:0]   vec_reg, vec_next;
   logic [DLY_W-1:0]   dly_reg, dly_next;
   logic               fail_reg, fail_next;
   logic [CNT_W-1:0]   err_reg, err_next;
   logic [VEC_W-1:0]   fvec_reg, fvec_next;
   logic               match;
   logic [SUM_W-1:0]   unused_exp;   // expected sum is only consumed inside the checker

   adder_ref_model u_ref (
      .a      (a),
      .b      (b),
      .Cin    (Cin),
      .Q      (Q),
      .select (select),
      .exp    (unused_exp),
      .match  (match)
   );

   // State, vector, hold counter, per-vector fail flag and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         vec_reg   <= '0;
         dly_reg   <= '0;
         fail_reg  <= 1'b0;
         err_reg   <= '0;
         fvec_reg  <= '0;
      end else begin
         state_reg <= state_next;
         vec_reg   <= vec_next;
         dly_reg   <= dly_next;
         fail_reg  <= fail_next;
         err_reg   <= err_next;
         fvec_reg  <= fvec_next;
      end
   end

   // Next-state logic; vec only moves on entry to APPLY so operands stay stable
   always_comb begin
      state_next = state_reg;
      vec_next   = vec_reg;
      dly_next   = dly_reg;
      fail_next  = fail_reg;
      err_next   = err_reg;
      fvec_next  = fvec_reg;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               vec_next   = '0;
               dly_next   = '0;
               fail_next  = 1'b0;
               err_next   = '0;
               fvec_next  = '0;
               state_next = APPLY;
            end
         end
         APPLY: begin
            if (dly_reg == DLY_LAST) begin
               dly_next   = '0;
               state_next = LOAD;
            end else begin
               dly_next = dly_reg + 1'b1;
            end
         end
         LOAD: begin
            state_next = CHK_RCA;
         end
         CHK_RCA: begin
            fail_next  = ~match;
            state_next = CHK_CLA;
         end
         CHK_CLA: begin
            fail_next  = fail_reg | ~match;
            state_next = NEXT;
         end
         NEXT: begin
            if (fail_reg) begin
               err_next = err_reg + 1'b1;
               if (err_reg == '0) begin
                  fvec_next = vec_reg;
               end
            end
            // Finishing has priority over advancing so vec never wraps
            if ((vec_reg == VEC_LAST) || (STOP_ON_FAIL && fail_reg)) begin
               state_next = DONE;
            end else begin
               vec_next   = vec_reg + 1'b1;
               dly_next   = '0;
               state_next = APPLY;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign a         = vec_reg[8:5];
   assign b         = vec_reg[4:1];
   assign Cin       = vec_reg[0];
   assign load      = (state_reg == LOAD);
   assign select    = (state_reg == CHK_CLA);
   assign busy      = (state_reg != IDLE) && (state_reg != DONE);
   assign done      = (state_reg == DONE);
   assign pass      = (state_reg == DONE) && (err_reg == '0);
   assign err_count = err_reg;
   assign fail_vec  = fvec_reg;

endmodule

// File: tb/tb_adder_test_sequencer.sv
// Bench: two sequencers (full sweep / stop-on-fail) against a faultable datapath model.
module tb_adder_test_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start  [2];
   logic [3:0] a_w    [2];
   logic [3:0] b_w    [2];
   logic       cin_w  [2];
   logic       load_w [2];
   logic       sel_w  [2];
   logic       busy_w [2];
   logic       done_w [2];
   logic       pass_w [2];
   logic [9:0] q_w    [2];
   logic [9:0] err_w  [2];
   logic [8:0] fv_w   [2];

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   adder_test_sequencer #(.PIPE_DLY(1), .STOP_ON_FAIL(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]),
      .a(a_w[0]), .b(b_w[0]), .Cin(cin_w[0]), .load(load_w[0]), .select(sel_w[0]),
      .Q(q_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .err_count(err_w[0]), .fail_vec(fv_w[0])
   );

   adder_test_sequencer #(.PIPE_DLY(2), .STOP_ON_FAIL(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]),
      .a(a_w[1]), .b(b_w[1]), .Cin(cin_w[1]), .load(load_w[1]), .select(sel_w[1]),
      .Q(q_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .err_count(err_w[1]), .fail_vec(fv_w[1])
   );

   // ---------------- datapath model with injectable faults ----------------
   // fault modes: 0 ideal, 1 Q[9] stuck at 0, 2 wrong RCA sum for vector 0x069,
   // 3 RCA result leaks into Q[9:5], 4 per-vector random faults from rkind/rmask
   int         fmode [2];
   logic [1:0] rkind [512];
   logic [4:0] rmask [512];
   logic [4:0] stg   [2];
   logic [4:0] rca   [2];
   logic [4:0] cla   [2];
   logic [8:0] ldv   [2];
   logic [4:0] r_t, c_t, stray_t;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         stg[i] <= 5'(a_w[i]) + 5'(b_w[i]) + 5'(cin_w[i]);
         if (load_w[i]) begin
            rca[i] <= stg[i];
            cla[i] <= stg[i];
            ldv[i] <= {a_w[i], b_w[i], cin_w[i]};
         end
      end
   end

   always_comb begin
      r_t = '0;
      c_t = '0;
      stray_t = '0;
      for (int i = 0; i < 2; i++) begin
         r_t = rca[i];
         c_t = cla[i];
         stray_t = '0;
         case (fmode[i])
            1: c_t[4] = 1'b0;
            2: if (ldv[i] == 9'h069) r_t = r_t ^ 5'd1;
            3: stray_t = rca[i];
            4: begin
               case (rkind[ldv[i]])
                  2'd1:    r_t = r_t ^ rmask[ldv[i]];
                  2'd2:    c_t = c_t ^ rmask[ldv[i]];
                  2'd3:    stray_t = rmask[ldv[i]];
                  default: ;
               endcase
            end
            default: ;
         endcase
         q_w[i] = sel_w[i] ? {c_t, 5'd0} : {stray_t, r_t};
      end
   end

   // ---------------- behavioural reference model ----------------
   int mact  [2];
   int mk    [2];      // cycles elapsed since the start edge
   int mend  [2];      // cycle offset at which done must be up
   int mfirst[2];      // first failing vector, -1 if none
   int mlast [2];      // last vector the sweep visits
   int pre   [2][513]; // pre[i][v] = failing vectors among 0..v-1

   function automatic bit vec_bad(input int mode, input int v);
      int s;
      s = ((v >> 5) & 15) + ((v >> 1) & 15) + (v & 1);
      case (mode)
         1:       return s >= 16;
         2:       return v == 9'h069;
         3:       return s != 0;
         4:       return rkind[v] != 2'd0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_start(input int i);
      int cnt;
      int len;
      len = (i == 0) ? 5 : 6;
      cnt = 0;
      mfirst[i] = -1;
      pre[i][0] = 0;
      for (int v = 0; v < 512; v++) begin
         if (vec_bad(fmode[i], v)) begin
            if (mfirst[i] < 0) mfirst[i] = v;
            cnt++;
         end
         pre[i][v+1] = cnt;
      end
      mlast[i] = (i == 1 && mfirst[i] >= 0) ? mfirst[i] : 511;
      mend[i]  = len * (mlast[i] + 1);
      mk[i]    = 0;
      mact[i]  = 1;
   endtask

   // Per-cycle compare of every output bundle against the model
   initial begin
      logic [32:0] want, act;
      int len, pd, vec, ph, ecnt;
      mact[0] = 0;
      mact[1] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!rst_n) mact[i] = 0;
            want = '0;
            if (mact[i] != 0) begin
               len = (i == 0) ? 5 : 6;
               pd  = len - 4;
               if (mk[i] < mend[i]) begin
                  vec = mk[i] / len;
                  ph  = mk[i] % len;
                  want = {4'(vec >> 5), 4'(vec >> 1), 1'(vec), (ph == pd), (ph == pd + 2),
                          1'b1, 1'b0, 1'b0, 10'(pre[i][vec]),
                          (mfirst[i] >= 0 && mfirst[i] < vec) ? 9'(mfirst[i]) : 9'd0};
               end else begin
                  vec  = mlast[i];
                  ecnt = pre[i][vec+1];
                  want = {4'(vec >> 5), 4'(vec >> 1), 1'(vec), 1'b0, 1'b0,
                          1'b0, 1'b1, (ecnt == 0), 10'(ecnt),
                          (mfirst[i] >= 0) ? 9'(mfirst[i]) : 9'd0};
               end
            end
            act = {a_w[i], b_w[i], cin_w[i], load_w[i], sel_w[i], busy_w[i], done_w[i],
                   pass_w[i], err_w[i], fv_w[i]};
            checks++;
            if (act !== want)
               $display("FAIL dut%0d outputs t=%0t got=%h want=%h", i, $time, act, want);
            else
               passed++;
            if (rst_n) begin
               if (start[i] && (mact[i] == 0 || mk[i] >= mend[i])) model_start(i);
               else if (mact[i] != 0 && mk[i] < mend[i]) mk[i]++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want)
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      else
         passed++;
   endtask

   function automatic logic [63:0] ctl(input int i);
      return 64'({a_w[i], b_w[i], cin_w[i], load_w[i], sel_w[i], busy_w[i], done_w[i], pass_w[i]});
   endfunction

   function automatic logic [63:0] stat(input int i);
      return 64'({err_w[i], fv_w[i]});
   endfunction

   // One sweep: start pulse, optional stray starts while busy, bounded wait for done
   task automatic run_sweep(input int i, input int mode, input bit noise, input int budget,
                            output int ncyc);
      fmode[i] = mode;
      start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
      ncyc = 0;
      while (!done_w[i] && ncyc < budget) begin
         start[i] = noise && ($urandom_range(0, 31) == 0);
         tick();
         start[i] = 1'b0;
         ncyc++;
      end
      if (!done_w[i]) begin
         checks++;
         $display("FAIL dut%0d sweep timeout: done=%0b after %0d cycles, required 1", i, done_w[i], ncyc);
      end
      $display("sweep dut%0d mode %0d: %0d cycles err_count=%0d fail_vec=%03h pass=%0b",
               i, mode, ncyc, err_w[i], fv_w[i], pass_w[i]);
   endtask

   task automatic new_table();
      for (int v = 0; v < 512; v++) begin
         rkind[v] = ($urandom_range(0, 59) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         rmask[v] = 5'($urandom_range(1, 31));
      end
   endtask

   initial begin
      int n0, n1;
      rst_n = 1'b0;
      start[0] = 1'b0;
      start[1] = 1'b0;
      fmode[0] = 0;
      fmode[1] = 0;
      for (int v = 0; v < 512; v++) begin
         rkind[v] = 2'd0;
         rmask[v] = 5'd1;
      end
      repeat (3) tick();
      chk("reset ctl dut0", ctl(0), 0);
      chk("reset status dut0", stat(0), 0);
      chk("reset ctl dut1", ctl(1), 0);
      rst_n = 1'b1;
      tick();

      // ideal datapath: full sweep, 512*5 cycles to done
      run_sweep(0, 0, 1'b0, 4000, n0);
      chk("ideal done latency", n0, 2560);
      chk("ideal pass", pass_w[0], 1);
      chk("ideal err_count", err_w[0], 0);
      chk("ideal fail_vec", fv_w[0], 0);

      // Q[9] stuck: every vector with sum >= 16 fails; restart from DONE, stray starts
      run_sweep(0, 1, 1'b1, 4000, n0);
      chk("stuck err_count", err_w[0], 256);
      chk("stuck fail_vec", fv_w[0], 9'h01F);
      chk("stuck pass", pass_w[0], 0);

      // stop-on-fail sequencer halts on a=3 b=4 Cin=1
      run_sweep(1, 2, 1'b1, 4000, n1);
      chk("stop done", done_w[1], 1);
      chk("stop err_count", err_w[1], 1);
      chk("stop fail_vec", fv_w[1], 9'h069);
      chk("stop operands", {a_w[1], b_w[1], cin_w[1]}, 9'h069);

      // async reset during CHK_CLA of vector 100
      fmode[0] = 0;
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      repeat (503) tick();
      chk("mid select", sel_w[0], 1);
      chk("mid vector", {a_w[0], b_w[0], cin_w[0]}, 100);
      rst_n = 1'b0;
      #1;
      chk("async reset ctl dut0", ctl(0), 0);
      chk("async reset status dut0", stat(0), 0);
      chk("async reset ctl dut1", ctl(1), 0);
      chk("async reset status dut1", stat(1), 0);
      tick();
      rst_n = 1'b1;
      tick();
      run_sweep(0, 0, 1'b0, 4000, n0);
      chk("resweep latency", n0, 2560);
      chk("resweep pass", pass_w[0], 1);

      // RCA result leaks into the CLA half: all but vector 0 fail
      run_sweep(0, 3, 1'b0, 4000, n0);
      chk("leak err_count", err_w[0], 511);
      chk("leak fail_vec", fv_w[0], 9'h001);

      // random fault tables, both sequencers concurrently, then stop-on-fail rounds
      new_table();
      fork
         run_sweep(0, 4, 1'b1, 4000, n0);
         run_sweep(1, 4, 1'b1, 4000, n1);
      join
      for (int r = 0; r < 3; r++) begin
         new_table();
         run_sweep(1, 4, 1'b1, 4000, n1);
      end
      tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
